insert_holes: RTL and testbench

INSERT_HOLES -- requirements
Module: insert_holes

---
 rtl/axi_fsrc_pkg.sv | 32 +++
 rtl/insert_holes.sv | 135 +++++++++++++
 tb/tb_insert_holes.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_fsrc_pkg.sv
// Shared helpers for the frame sparse/dense conversion paths (RX and TX).
// Masks are passed zero-extended to MAX_WORDS bits so one function serves every beat width.
package axi_fsrc_pkg;

   localparam int MAX_WORDS = 32;

   // Number of set bits among the low numWords bits of mask.
   function automatic int popCount(input logic [MAX_WORDS-1:0] mask, input int numWords);
      int total;
      total = 0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         if ((i < numWords) && mask[i]) begin
            total++;
         end
      end
      return total;
   endfunction

   // Number of clear bits strictly below position pos, i.e. how many data words
   // land in lower output positions than pos.
   function automatic int prefixCount(input logic [MAX_WORDS-1:0] mask, input int pos);
      int total;
      total = 0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         if ((i < pos) && !mask[i]) begin
            total++;
         end
      end
      return total;
   endfunction

endpackage

// File: rtl/insert_holes.sv
// InsertHoles: takes dense beats of NUM_WORDS words and spreads them over output
// beats according to a hole mask, filling hole positions with zero. Words are kept
// in a 2*NUM_WORDS deep order-preserving buffer; a beat is pushed only when it fits.
module insert_holes
   import axi_fsrc_pkg::*;
#(
   parameter int WORD_LENGTH = 16,
   parameter int NUM_WORDS   = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [WORD_LENGTH*NUM_WORDS-1:0] in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_WORDS-1:0]             holes,
   input  logic                             holes_valid,
   output logic                             holes_ready,
   output logic [WORD_LENGTH*NUM_WORDS-1:0] out_data,
   output logic [NUM_WORDS-1:0]             out_holes,
   output logic                             out_valid,
   output logic [15:0]                      underflow_cnt
);

   localparam int DEPTH = 2 * NUM_WORDS;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [WORD_LENGTH-1:0] word_t;

   word_t                            bufQ [DEPTH];
   word_t                            bufD [DEPTH];
   logic [CNT_W-1:0]                 cntQ, cntD;
   logic [WORD_LENGTH*NUM_WORDS-1:0] outDataQ, outDataD;
   logic [NUM_WORDS-1:0]             outHolesQ;
   logic                             outValidQ;
   logic [15:0]                      underflowQ;

   logic [MAX_WORDS-1:0]             holesWide;
   int                               need;
   logic                             holesAccept;
   logic                             pushAccept;

   // Mask decode: how many buffered words this output beat consumes.
   always_comb begin
      holesWide                 = '0;
      holesWide[NUM_WORDS-1:0]  = holes;
      need                      = NUM_WORDS - popCount(holesWide, NUM_WORDS);
   end

   // Handshakes depend only on the registered occupancy and the incoming mask.
   always_comb begin
      in_ready    = (int'(cntQ) <= NUM_WORDS);
      holes_ready = (int'(cntQ) >= need);
      holesAccept = holes_valid && holes_ready;
      pushAccept  = in_valid && in_ready;
   end

   // Buffer update: drop the popped words from the head, then append any new beat
   // behind whatever remains, so a same-cycle push never feeds the current pop.
   always_comb begin
      int             popN;
      int             remain;
      logic [IDX_W-1:0] srcIdx;
      logic [IDX_W-1:0] dstIdx;
      popN   = holesAccept ? need : 0;
      remain = int'(cntQ) - popN;
      srcIdx = '0;
      dstIdx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         bufD[i] = bufQ[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < remain) && (i + popN < DEPTH)) begin
            srcIdx  = IDX_W'(i + popN);
            bufD[i] = bufQ[srcIdx];
         end
      end
      if (pushAccept) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (remain + k < DEPTH) begin
               dstIdx       = IDX_W'(remain + k);
               bufD[dstIdx] = in_data[k*WORD_LENGTH +: WORD_LENGTH];
            end
         end
      end
      cntD = CNT_W'(remain + (pushAccept ? NUM_WORDS : 0));
   end

   // Placement mux: each non-hole position takes the oldest word not claimed by a lower position.
   always_comb begin
      logic [IDX_W-1:0] srcIdx;
      srcIdx   = '0;
      outDataD = '0;
      for (int j = 0; j < NUM_WORDS; j++) begin
         if (!holes[j]) begin
            srcIdx = IDX_W'(prefixCount(holesWide, j));
            outDataD[j*WORD_LENGTH +: WORD_LENGTH] = bufQ[srcIdx];
         end
      end
   end

   // Word storage carries no reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         bufQ[i] <= bufD[i];
      end
   end

   // Occupancy, output beat register and starvation counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cntQ       <= '0;
         outDataQ   <= '0;
         outHolesQ  <= '0;
         outValidQ  <= 1'b0;
         underflowQ <= '0;
      end else begin
         cntQ      <= cntD;
         outValidQ <= holesAccept;
         if (holesAccept) begin
            outDataQ  <= outDataD;
            outHolesQ <= holes;
         end
         if (holes_valid && !holes_ready && (underflowQ != 16'hFFFF)) begin
            underflowQ <= underflowQ + 16'd1;
         end
      end
   end

   assign out_data      = outDataQ;
   assign out_holes     = outHolesQ;
   assign out_valid     = outValidQ;
   assign underflow_cnt = underflowQ;

endmodule

// File: tb/tb_insert_holes.sv
// Testbench for insert_holes: directed beats and masks, expected output beats
// queued by the stimulus and checked by an independent monitor.
module tb_insert_holes;

   localparam int WL = 16;
   localparam int NW = 4;

   logic              clk;
   logic              reset;
   logic [WL*NW-1:0]  in_data;
   logic              in_valid;
   logic              in_ready;
   logic [NW-1:0]     holes;
   logic              holes_valid;
   logic              holes_ready;
   logic [WL*NW-1:0]  out_data;
   logic [NW-1:0]     out_holes;
   logic              out_valid;
   logic [15:0]       underflow_cnt;

   typedef struct packed {
      logic [WL*NW-1:0] data;
      logic [NW-1:0]    mask;
   } beat_t;

   beat_t expectedQ[$];
   int    assertionCount = 0;
   int    failCount      = 0;

   insert_holes #(.WORD_LENGTH(WL), .NUM_WORDS(NW)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .holes        (holes),
      .holes_valid  (holes_valid),
      .holes_ready  (holes_ready),
      .out_data     (out_data),
      .out_holes    (out_holes),
      .out_valid    (out_valid),
      .underflow_cnt(underflow_cnt)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertionCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one cycle of push and/or mask, then release both qualifiers.
   task automatic applyStimulus(input logic pushEn, input logic [WL*NW-1:0] data,
                                input logic maskEn, input logic [NW-1:0] mask);
      in_valid    = pushEn;
      in_data     = data;
      holes_valid = maskEn;
      holes       = mask;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      holes_valid = 1'b0;
   endtask

   task automatic expectBeat(input logic [WL*NW-1:0] data, input logic [NW-1:0] mask);
      beat_t b;
      b.data = data;
      b.mask = mask;
      expectedQ.push_back(b);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every output beat must match the oldest expected beat.
   always @(negedge clk) begin
      beat_t b;
      if (!reset && out_valid) begin
         if (expectedQ.size() == 0) begin
            checkOutput("unexpectedBeat", {63'd0, out_valid}, 64'd0);
         end else begin
            b = expectedQ.pop_front();
            checkOutput("beatData", out_data, b.data);
            checkOutput("beatHoles", {60'd0, out_holes}, {60'd0, b.mask});
         end
      end
   end

   initial begin
      reset       = 1'b1;
      in_data     = '0;
      in_valid    = 1'b0;
      holes       = '0;
      holes_valid = 1'b0;
      idle(2);

      // Reset state
      checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
      checkOutput("rstOutData", out_data, 64'd0);
      checkOutput("rstUnderflow", {48'd0, underflow_cnt}, 64'd0);
      reset = 1'b0;
      idle(1);
      checkOutput("rstInReady", {63'd0, in_ready}, 64'd1);
      holes = 4'b1111;
      #1;
      checkOutput("rstAllHolesReady", {63'd0, holes_ready}, 64'd1);
      holes = 4'b0000;
      #1;
      checkOutput("rstDenseNotReady", {63'd0, holes_ready}, 64'd0);

      // Starved mask held for three cycles
      holes_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("starvedReady", {63'd0, holes_ready}, 64'd0);
         @(posedge clk);
         #1;
      end
      holes_valid = 1'b0;
      checkOutput("underflowThree", {48'd0, underflow_cnt}, 64'd3);

      // Dense pass-through
      applyStimulus(1'b1, 64'h0004_0003_0002_0001, 1'b0, 4'b0000);
      expectBeat(64'h0004_0003_0002_0001, 4'b0000);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b0000);
      checkOutput("denseCnt", {60'd0, dut.cntQ}, 64'd0);

      // Interleaved hole patterns
      applyStimulus(1'b1, 64'h0004_0003_0002_0001, 1'b0, 4'b0000);
      expectBeat(64'h0002_0000_0001_0000, 4'b0101);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b0101);
      expectBeat(64'h0000_0004_0000_0003, 4'b1010);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b1010);

      // All-holes mask with an empty buffer
      expectBeat(64'h0, 4'b1111);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b1111);
      checkOutput("allHolesCnt", {60'd0, dut.cntQ}, 64'd0);

      // Fill to capacity, then pop while pushing
      applyStimulus(1'b1, 64'h0014_0013_0012_0011, 1'b0, 4'b0000);
      applyStimulus(1'b1, 64'h0024_0023_0022_0021, 1'b0, 4'b0000);
      checkOutput("fullCnt", {60'd0, dut.cntQ}, 64'd8);
      checkOutput("fullInReady", {63'd0, in_ready}, 64'd0);
      expectBeat(64'h0014_0013_0012_0011, 4'b0000);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b0000);
      checkOutput("halfCnt", {60'd0, dut.cntQ}, 64'd4);
      expectBeat(64'h0024_0023_0022_0021, 4'b0000);
      applyStimulus(1'b1, 64'h0034_0033_0032_0031, 1'b1, 4'b0000);
      checkOutput("pushPopCnt", {60'd0, dut.cntQ}, 64'd4);
      expectBeat(64'h0034_0033_0032_0031, 4'b0000);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b0000);

      // Partial pops with a push appended behind the leftovers
      applyStimulus(1'b1, 64'h0044_0043_0042_0041, 1'b0, 4'b0000);
      expectBeat(64'h0000_0000_0042_0041, 4'b1100);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b1100);
      checkOutput("partialCnt", {60'd0, dut.cntQ}, 64'd2);
      expectBeat(64'h0044_0043_0000_0000, 4'b0011);
      applyStimulus(1'b1, 64'h0054_0053_0052_0051, 1'b1, 4'b0011);
      checkOutput("appendCnt", {60'd0, dut.cntQ}, 64'd4);
      expectBeat(64'h0054_0053_0052_0051, 4'b0000);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b0000);
      idle(2);

      // Reset mid-stream with six words buffered and a beat on the output
      applyStimulus(1'b1, 64'h0064_0063_0062_0061, 1'b0, 4'b0000);
      applyStimulus(1'b1, 64'h0074_0073_0072_0071, 1'b0, 4'b0000);
      holes       = 4'b1100;
      holes_valid = 1'b1;
      @(posedge clk);
      #1;
      holes_valid = 1'b0;
      checkOutput("preRstValid", {63'd0, out_valid}, 64'd1);
      checkOutput("preRstData", out_data, 64'h0000_0000_0062_0061);
      checkOutput("preRstCnt", {60'd0, dut.cntQ}, 64'd6);
      reset = 1'b1;
      #1;
      checkOutput("midRstValid", {63'd0, out_valid}, 64'd0);
      checkOutput("midRstCnt", {60'd0, dut.cntQ}, 64'd0);
      checkOutput("midRstData", out_data, 64'd0);
      idle(1);
      reset = 1'b0;
      idle(1);
      checkOutput("postRstInReady", {63'd0, in_ready}, 64'd1);
      holes       = 4'b0000;
      holes_valid = 1'b1;
      #1;
      checkOutput("postRstNotReady", {63'd0, holes_ready}, 64'd0);
      @(posedge clk);
      #1;
      holes_valid = 1'b0;
      checkOutput("postRstUnderflow", {48'd0, underflow_cnt}, 64'd1);
      applyStimulus(1'b1, 64'h0084_0083_0082_0081, 1'b0, 4'b0000);
      expectBeat(64'h0084_0083_0082_0081, 4'b0000);
      applyStimulus(1'b0, 64'h0, 1'b1, 4'b0000);
      idle(3);

      checkOutput("scoreboardDrained", 64'(expectedQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
      $finish;
   end

endmodule
